// File: rtl/shk_iic_cfg_seq.sv
// Register-init sequencer: walks a synchronous table of {reg_addr, reg_data}
// entries and turns each write entry into one shake write transaction.
`timescale 1ns/1ps
module shk_iic_cfg_seq #(
  parameter int         MD_SIM_ABLE   = 0,
  parameter int         NB_SYS_PER    = 10,
  parameter logic [6:0] NB_DEV_ADDR   = 7'h3C,
  parameter int         NB_PWR_DLY_MS = 20,
  parameter int         NB_RDY_TMO    = 2_000_000,
  parameter int         WD_TAB_ADDR   = 8,
  parameter int         WD_SHK_DATA   = 8,
  parameter int         WD_SHK_ADDR   = 16,
  parameter int         WD_ERR_INFO   = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   i_cfg_start,
  output logic [WD_TAB_ADDR-1:0] m_tab_addr,
  input  logic [23:0]            m_tab_data,
  output logic                   m_shk_0_valid,
  output logic                   m_shk_0_msync,
  output logic [WD_SHK_DATA-1:0] m_shk_0_mdata,
  output logic [WD_SHK_DATA-1:0] m_shk_0_mdat1,
  output logic [WD_SHK_ADDR-1:0] m_shk_0_maddr,
  input  logic                   m_shk_0_ready,
  output logic                   o_cfg_busy,
  output logic                   o_cfg_done,
  output logic                   o_cfg_err,
  output logic [WD_ERR_INFO-1:0] m_err_shk_info1
);

  localparam int MS_CLKS = (MD_SIM_ABLE != 0) ? 100 : 1_000_000 / NB_SYS_PER;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_FETCH, S_DECODE, S_ISSUE, S_BURST,
    S_WAIT_RDY, S_GAP, S_DELAY, S_DONE, S_ERR
  } state_t;

  state_t                 state_q;
  logic [WD_TAB_ADDR-1:0] idx_q;
  logic [23:0]            entry_q;
  logic                   fetch_ph_q;
  logic [1:0]             bcnt_q;
  logic [31:0]            tick_q;
  logic [15:0]            ms_left_q;
  logic [31:0]            tmo_q;
  logic                   valid_q;
  logic                   msync_q;
  logic [WD_SHK_DATA-1:0] mdata_q;
  logic [WD_SHK_ADDR-1:0] maddr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic [WD_ERR_INFO-1:0] info_q;

  logic [WD_TAB_ADDR-1:0] idx_inc_d;
  logic                   tick_wrap_d;
  logic                   is_end_d;
  logic                   is_dly_d;

  assign idx_inc_d   = idx_q + WD_TAB_ADDR'(1);
  assign tick_wrap_d = (tick_q == 32'(MS_CLKS - 1));
  assign is_end_d    = (entry_q[23:8] == 16'hFFFF);
  assign is_dly_d    = (entry_q[23:8] == 16'hFFFE);

  // Byte order on the shake bus: device address (write), reg hi, reg lo, data.
  function automatic logic [7:0] burst_byte(input logic [1:0] sel, input logic [23:0] ent);
    case (sel)
      2'd0:    burst_byte = {NB_DEV_ADDR, 1'b0};
      2'd1:    burst_byte = ent[23:16];
      2'd2:    burst_byte = ent[15:8];
      default: burst_byte = ent[7:0];
    endcase
  endfunction

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      entry_q    <= '0;
      fetch_ph_q <= 1'b0;
      bcnt_q     <= '0;
      tick_q     <= '0;
      ms_left_q  <= '0;
      tmo_q      <= '0;
      valid_q    <= 1'b0;
      msync_q    <= 1'b0;
      mdata_q    <= '0;
      maddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      info_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_cfg_start) begin
            idx_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            info_q    <= '0;
            busy_q    <= 1'b1;
            tick_q    <= '0;
            ms_left_q <= 16'(NB_PWR_DLY_MS);
            state_q   <= S_PWR_WAIT;
          end
        end

        S_PWR_WAIT: begin
          if (ms_left_q == 16'd0) begin
            fetch_ph_q <= 1'b0;
            state_q    <= S_FETCH;
          end else if (tick_wrap_d) begin
            tick_q    <= '0;
            ms_left_q <= ms_left_q - 16'd1;
          end else begin
            tick_q <= tick_q + 32'd1;
          end
        end

        // Address has been stable since the index last changed; the ROM
        // needs one more cycle before its output reflects it.
        S_FETCH: begin
          if (!fetch_ph_q) begin
            fetch_ph_q <= 1'b1;
          end else begin
            entry_q <= m_tab_data;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_end_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (is_dly_d) begin
            ms_left_q <= {8'h00, entry_q[7:0]};
            tick_q    <= '0;
            state_q   <= S_DELAY;
          end else begin
            valid_q <= 1'b1;
            maddr_q <= WD_SHK_ADDR'(idx_q);
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          msync_q <= 1'b1;
          mdata_q <= WD_SHK_DATA'(burst_byte(2'd0, entry_q));
          bcnt_q  <= 2'd0;
          state_q <= S_BURST;
        end

        S_BURST: begin
          if (bcnt_q == 2'd3) begin
            msync_q <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_WAIT_RDY;
          end else begin
            mdata_q <= WD_SHK_DATA'(burst_byte(bcnt_q + 2'd1, entry_q));
            bcnt_q  <= bcnt_q + 2'd1;
          end
        end

        // Ready has priority over a timeout firing in the same cycle.
        S_WAIT_RDY: begin
          if (m_shk_0_ready) begin
            state_q <= S_GAP;
          end else if (tmo_q == 32'(NB_RDY_TMO - 1)) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            info_q  <= WD_ERR_INFO'(1);
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end

        // GAP always advances after its single cycle; DELAY advances once
        // its millisecond count has run out. A wrap to 0 means no end marker.
        S_GAP, S_DELAY: begin
          if (state_q == S_GAP || ms_left_q == 16'd0) begin
            idx_q <= idx_inc_d;
            if (idx_inc_d == '0) begin
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              info_q  <= WD_ERR_INFO'(2);
              state_q <= S_ERR;
            end else begin
              fetch_ph_q <= 1'b0;
              state_q    <= S_FETCH;
            end
          end else if (tick_wrap_d) begin
            tick_q    <= '0;
            ms_left_q <= ms_left_q - 16'd1;
          end else begin
            tick_q <= tick_q + 32'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_tab_addr      = idx_q;
  assign m_shk_0_valid   = valid_q;
  assign m_shk_0_msync   = msync_q;
  assign m_shk_0_mdata   = mdata_q;
  assign m_shk_0_mdat1   = '0;
  assign m_shk_0_maddr   = maddr_q;
  assign o_cfg_busy      = busy_q;
  assign o_cfg_done      = done_q;
  assign o_cfg_err       = err_q;
  assign m_err_shk_info1 = info_q;

endmodule

// File: tb/tb_shk_iic_cfg_seq.sv
// Directed bench for shk_iic_cfg_seq: a 4-entry synchronous table model and
// a scripted slave ready pulse, checked with immediate assertions.
`timescale 1ns/1ps
module tb_shk_iic_cfg_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  tab_addr;
  logic [23:0] tab_data;
  logic        valid;
  logic        msync;
  logic [7:0]  mdata;
  logic [7:0]  mdat1;
  logic [15:0] maddr;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  info;

  logic [23:0] rom [4];

  int tests;
  int fails;
  int msync_cnt;
  int valid_cnt;
  int overlap_cnt;

  shk_iic_cfg_seq #(
    .MD_SIM_ABLE   (1),
    .NB_SYS_PER    (10),
    .NB_DEV_ADDR   (7'h3C),
    .NB_PWR_DLY_MS (1),
    .NB_RDY_TMO    (50),
    .WD_TAB_ADDR   (2),
    .WD_SHK_DATA   (8),
    .WD_SHK_ADDR   (16),
    .WD_ERR_INFO   (4)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_resetn    (rst_n),
    .i_cfg_start     (start),
    .m_tab_addr      (tab_addr),
    .m_tab_data      (tab_data),
    .m_shk_0_valid   (valid),
    .m_shk_0_msync   (msync),
    .m_shk_0_mdata   (mdata),
    .m_shk_0_mdat1   (mdat1),
    .m_shk_0_maddr   (maddr),
    .m_shk_0_ready   (ready),
    .o_cfg_busy      (busy),
    .o_cfg_done      (done),
    .o_cfg_err       (err),
    .m_err_shk_info1 (info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tab_data <= rom[tab_addr];

  initial begin
    msync_cnt   = 0;
    valid_cnt   = 0;
    overlap_cnt = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (msync)          msync_cnt   <= msync_cnt + 1;
      if (valid)          valid_cnt   <= valid_cnt + 1;
      if (valid && msync) overlap_cnt <= overlap_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    while (!valid && n < limit) begin
      step();
      n++;
    end
    check({tag, "_valid_seen"}, valid, 1'b1);
  endtask

  // Called in the valid cycle; walks the four byte strobes and the drop.
  task automatic check_burst(input string tag, input logic [23:0] ent, input logic [15:0] idx);
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h78;
    exp_b[1] = ent[23:16];
    exp_b[2] = ent[15:8];
    exp_b[3] = ent[7:0];
    check({tag, "_maddr"}, maddr, idx);
    check({tag, "_mdat1"}, mdat1, 8'h00);
    check({tag, "_msync_in_valid"}, msync, 1'b0);
    for (int b = 0; b < 4; b++) begin
      step();
      check($sformatf("%s_msync%0d", tag, b), msync, 1'b1);
      check($sformatf("%s_valid_low%0d", tag, b), valid, 1'b0);
      check($sformatf("%s_mdata%0d", tag, b), mdata, exp_b[b]);
    end
    step();
    check({tag, "_msync_drop"}, msync, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(done || err) && n < 100) begin
      step();
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    int n;
    int n2;
    int m0;
    int v0;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = 24'hFFFF00;

    // Reset state
    repeat (3) step();
    check("rst_valid", valid, 1'b0);
    check("rst_msync", msync, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_info", info, 4'h0);
    check("rst_tab_addr", tab_addr, 2'd0);
    check("rst_maddr", maddr, 16'h0);
    rst_n = 1'b1;
    repeat (2) step();

    // T1: single write then end; 1 ms power wait (100 clocks) precedes it
    rom[0] = 24'h300882;
    rom[1] = 24'hFFFF00;
    m0 = msync_cnt;
    v0 = valid_cnt;
    pulse_start();
    check("t1_busy", busy, 1'b1);
    wait_valid("t1", 200, n);
    check("t1_pwr_lat_min", n >= 101, 1'b1);
    check("t1_pwr_lat_max", n <= 106, 1'b1);
    check_burst("t1", 24'h300882, 16'd0);
    repeat (30) step();
    pulse_ready();
    wait_done("t1");
    check("t1_info", info, 4'h0);
    check("t1_tab_addr", tab_addr, 2'd1);
    check("t1_msync_cnt", msync_cnt - m0, 4);
    check("t1_valid_cnt", valid_cnt - v0, 1);
    $display("[TB] T1 single write: n=%0d", n);

    // T2: three writes, a start while busy is ignored
    rom[0] = 24'h1234AB;
    rom[1] = 24'h0102C3;
    rom[2] = 24'hABCD5A;
    rom[3] = 24'hFFFF00;
    m0 = msync_cnt;
    v0 = valid_cnt;
    pulse_start();
    wait_valid("t2a", 200, n);
    check_burst("t2a", 24'h1234AB, 16'd0);
    repeat (5) step();
    pulse_start();
    check("t2_busy_hold", busy, 1'b1);
    check("t2_done_hold", done, 1'b0);
    repeat (5) step();
    pulse_ready();
    wait_valid("t2b", 20, n);
    check("t2b_gap", n >= 2, 1'b1);
    check_burst("t2b", 24'h0102C3, 16'd1);
    repeat (10) step();
    pulse_ready();
    wait_valid("t2c", 20, n);
    check("t2c_gap", n >= 2, 1'b1);
    check_burst("t2c", 24'hABCD5A, 16'd2);
    pulse_ready();
    wait_done("t2");
    check("t2_msync_cnt", msync_cnt - m0, 12);
    check("t2_valid_cnt", valid_cnt - v0, 3);
    $display("[TB] T2 three writes: msync=%0d valid=%0d", msync_cnt - m0, valid_cnt - v0);

    // T3: 5 ms delay entry between writes; stray ready during the delay
    rom[0] = 24'h111122;
    rom[1] = 24'hFFFE05;
    rom[2] = 24'h333344;
    rom[3] = 24'hFFFF00;
    pulse_start();
    wait_valid("t3a", 200, n);
    check_burst("t3a", 24'h111122, 16'd0);
    repeat (5) step();
    pulse_ready();
    m0 = msync_cnt;
    v0 = valid_cnt;
    repeat (100) step();
    pulse_ready();
    wait_valid("t3b", 1000, n2);
    n = 101 + n2;
    check("t3_dly_min", n >= 500, 1'b1);
    check("t3_dly_max", n <= 512, 1'b1);
    check("t3_quiet_msync", msync_cnt - m0, 0);
    check("t3_quiet_valid", valid_cnt - v0, 0);
    check_burst("t3b", 24'h333344, 16'd2);
    pulse_ready();
    wait_done("t3");
    $display("[TB] T3 delay entry: ready->valid=%0d", n);

    // T4: no ready -> timeout at cycle 50 of WAIT_RDY, then restart
    rom[0] = 24'h5678AA;
    rom[1] = 24'hFFFF00;
    pulse_start();
    wait_valid("t4a", 200, n);
    check_burst("t4a", 24'h5678AA, 16'd0);
    n = 0;
    while (!err && n < 100) begin
      step();
      n++;
    end
    check("t4_tmo_cycle", n, 50);
    check("t4_err", err, 1'b1);
    check("t4_info", info, 4'b0001);
    check("t4_busy", busy, 1'b0);
    check("t4_done", done, 1'b0);
    pulse_start();
    check("t4_restart_err", err, 1'b0);
    check("t4_restart_info", info, 4'h0);
    check("t4_restart_busy", busy, 1'b1);
    check("t4_restart_idx", tab_addr, 2'd0);
    wait_valid("t4b", 200, n);
    check_burst("t4b", 24'h5678AA, 16'd0);
    pulse_ready();
    wait_done("t4");
    $display("[TB] T4 timeout and restart");

    // T5: four writes, no end marker -> overrun error after 4th ready
    rom[0] = 24'h010101;
    rom[1] = 24'h020202;
    rom[2] = 24'h030303;
    rom[3] = 24'h040404;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("t5_%0d", i), 200, n);
      check_burst($sformatf("t5_%0d", i), rom[i], 16'(i));
      repeat (3) step();
      pulse_ready();
    end
    n = 0;
    while (!err && n < 20) begin
      step();
      n++;
    end
    check("t5_err", err, 1'b1);
    check("t5_info", info, 4'b0010);
    check("t5_done", done, 1'b0);
    check("t5_busy", busy, 1'b0);
    $display("[TB] T5 table overrun");

    // T6: async reset during burst byte 2
    rom[0] = 24'h300882;
    rom[1] = 24'hFFFF00;
    pulse_start();
    wait_valid("t6a", 200, n);
    repeat (3) step();
    check("t6_msync_b2", msync, 1'b1);
    check("t6_mdata_b2", mdata, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_msync", msync, 1'b0);
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_mdata", mdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    m0 = msync_cnt;
    v0 = valid_cnt;
    repeat (300) step();
    check("t6_idle_msync", msync_cnt - m0, 0);
    check("t6_idle_valid", valid_cnt - v0, 0);
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_done", done, 1'b0);
    pulse_start();
    check("t6_start_busy", busy, 1'b1);
    wait_valid("t6b", 200, n);
    check_burst("t6b", 24'h300882, 16'd0);
    pulse_ready();
    wait_done("t6");
    $display("[TB] T6 reset mid-burst and recovery");

    check("valid_msync_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shk_iic_cfg_seq.md
Name: shk_iic_cfg_seq

Overview:
- Upstream master for shk_to_iic. Walks a register-init table (sensor bring-up) and turns each entry into one shake write transaction: device address, register address hi, register address lo, data.
- Honours delay entries and an end marker, waits for the slave's ready pulse between transactions, and reports done/error to the system.

Parameters:
- MD_SIM_ABLE, 0, 1 = one "ms" is 100 clocks (sim speed-up).
- NB_SYS_PER, 10, system clock period, ns.
- NB_DEV_ADDR, 7'h3C, 7-bit IIC device address; first byte sent is {NB_DEV_ADDR,1'b0}.
- NB_PWR_DLY_MS, 20, ms to wait after start before the first transaction.
- NB_RDY_TMO, 2_000_000, clocks to wait for s_shk_0_ready before timeout.
- WD_TAB_ADDR, 8, table index width; table depth is 2**WD_TAB_ADDR.
- WD_SHK_DATA, 8, shake data width.
- WD_SHK_ADDR, 16, shake address width.
- WD_ERR_INFO, 4, error field width.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_resetn  in  1  asynchronous active-low reset.
- i_cfg_start  in  1  one-cycle pulse; starts the table walk; ignored unless in IDLE, DONE or ERR.
- m_tab_addr  out  WD_TAB_ADDR  table read index.
- m_tab_data  in  24  {reg_addr[15:0], reg_data[7:0]}; valid one cycle after m_tab_addr changes (synchronous ROM).
- m_shk_0_valid  out  1  transaction request pulse.
- m_shk_0_msync  out  1  write-byte strobe.
- m_shk_0_mdata  out  WD_SHK_DATA  write byte.
- m_shk_0_mdat1  out  WD_SHK_DATA  read length; constant 0.
- m_shk_0_maddr  out  WD_SHK_ADDR  zero-extended table index of the entry in flight.
- m_shk_0_ready  in  1  transaction complete pulse from the slave.
- o_cfg_busy  out  1  high from accepted start until DONE or ERR.
- o_cfg_done  out  1  level; table completed without error.
- o_cfg_err  out  1  level; sequence aborted.
- m_err_shk_info1  out  WD_ERR_INFO  bit0 ready timeout; bit1 table overrun (no end marker); other bits 0.

Behaviour:
- Reset: all outputs 0; state IDLE.
- Entry decode:
  - reg_addr 16'hFFFF = end.
  - reg_addr 16'hFFFE = delay of reg_data ms; reg_data 0 means no delay.
  - Any other value = write entry.
- One ms = 1_000_000/NB_SYS_PER clocks, or 100 when MD_SIM_ABLE = 1.
- States:
  - IDLE: on i_cfg_start, clear index/done/err/info, set busy, go to PWR_WAIT.
  - PWR_WAIT: count NB_PWR_DLY_MS ms, then go to FETCH.
  - FETCH: drive m_tab_addr, wait 1 cycle, register m_tab_data, go to DECODE.
  - DECODE: end -> DONE. Delay -> DELAY. Write -> ISSUE.
  - ISSUE: m_shk_0_valid = 1 for exactly 1 cycle, maddr = index, mdat1 = 0.
  - BURST: in the 4 cycles immediately after the valid cycle, msync = 1 each cycle. mdata, in order: {NB_DEV_ADDR,0}, reg_addr[15:8], reg_addr[7:0], reg_data. msync is deasserted afterwards and the tmo counter is cleared. The slave requires all msync bytes within its first SCL period, so its NB_SCL_CNT must be >= 5.
  - WAIT_RDY: on m_shk_0_ready -> GAP. If the tmo counter reaches NB_RDY_TMO-1 -> ERR with info bit0.
  - GAP: 1 idle cycle, so the slave is back in its IDLE before the next valid. Then index += 1. If the index wraps to 0 (past last entry without end) -> ERR with info bit1; else -> FETCH.
  - DELAY: count reg_data ms, then index += 1, same wrap check, then FETCH.
  - DONE: busy = 0, done = 1. On i_cfg_start, restart as from IDLE.
  - ERR: busy = 0, err = 1, info held. On i_cfg_start, restart.
- i_cfg_start while busy: ignored.
- Ready outside WAIT_RDY: ignored.
- Ready arriving in the same cycle the timeout would fire: ready wins.
- valid and msync are never high in the same cycle.
- Async reset mid-transaction: outputs drop to 0 immediately and the sequence does not resume. The system must also reset the slave.

Test Plan:
- Table {0x3008,0x82},{0xFFFF,x}, NB_PWR_DLY_MS = 1, sim mode, start -> after 100 clocks one valid, maddr = 0. Next 4 cycles msync with mdata 0x78, 0x30, 0x08, 0x82. Ready after 30 clocks -> GAP, fetch index 1, done = 1, busy = 0, err = 0.
- Three write entries, then end -> three valid pulses with maddr 0, 1, 2. Each valid is issued >= 2 cycles after the previous ready. Exactly 12 msync strobes total.
- Entry {0xFFFE,5} between two writes -> second valid follows first ready by 500 + fetch/decode cycles (+/-3). No shake activity during the delay.
- Ready never returned, NB_RDY_TMO = 50 -> err = 1, m_err_shk_info1 = 4'b0001 at cycle 50 of WAIT_RDY. New start restarts from index 0.
- WD_TAB_ADDR = 2, four writes, no end marker -> after the 4th ready: err = 1, info = 4'b0010.
- Reset asserted during BURST byte 2 -> msync/valid/busy go 0 asynchronously. After release, no activity until i_cfg_start. A start pulse during busy changes nothing.
